// File: rtl/debounce_multi_pkg.sv
// Constants shared by the debounce filters: default qualification time,
// threshold clamp rule and the per-channel strobe encoding.
package debounce_multi_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT_TH = 32'h0003_0D3F;

  // One-hot so that each strobe output is a direct flop bit.
  localparam int STRB_RISE_BIT   = 0;
  localparam int STRB_FALL_BIT   = 1;
  localparam int STRB_GLITCH_BIT = 2;

  typedef enum logic [2:0] {
    STRB_NONE   = 3'b000,
    STRB_RISE   = 3'b001,
    STRB_FALL   = 3'b010,
    STRB_GLITCH = 3'b100
  } strb_e;

  // A zero qualification time would never match cnt == th-1, so it means 1.
  function automatic int unsigned clamp_th(input int unsigned th);
    return (th == 0) ? 32'd1 : th;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: two-flop synchroniser, saturating stability counter
// with rise/fall threshold mux, and registered one-cycle strobes.
module debounce_ch
  import debounce_multi_pkg::*;
#(
  parameter int unsigned     DW      = 20,
  parameter logic [DW-1:0]   RISE_TH = DW'(DEBOUNCE_DEFAULT_TH),
  parameter logic [DW-1:0]   FALL_TH = DW'(DEBOUNCE_DEFAULT_TH),
  parameter logic            RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic signal_in,
  output logic signal_out,
  output logic rise_strb,
  output logic fall_strb,
  output logic glitch_strb
);

  localparam logic [DW-1:0] RISE_M1 = DW'(clamp_th(32'(RISE_TH)) - 32'd1);
  localparam logic [DW-1:0] FALL_M1 = DW'(clamp_th(32'(FALL_TH)) - 32'd1);

  logic          z1;
  logic          z2;
  logic [DW-1:0] cnt;
  logic [DW-1:0] th_m1;
  logic          pend;
  strb_e         strb;

  assign th_m1 = signal_out ? FALL_M1 : RISE_M1;
  assign pend  = (z2 != signal_out) && (z1 == z2);

  // Counter saturates at th-1: reaching it accepts the change and clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      z1         <= RST_VAL;
      z2         <= RST_VAL;
      signal_out <= RST_VAL;
      cnt        <= '0;
      strb       <= STRB_NONE;
    end else begin
      z1   <= signal_in;
      z2   <= z1;
      strb <= STRB_NONE;
      if (!enable) begin
        cnt <= '0;
      end else if (pend) begin
        if (cnt >= th_m1) begin
          signal_out <= z2;
          cnt        <= '0;
          if (z2) strb <= STRB_RISE;
          else    strb <= STRB_FALL;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (cnt != '0) begin
        cnt  <= '0;
        strb <= STRB_GLITCH;
      end
    end
  end

  assign rise_strb   = strb[STRB_RISE_BIT];
  assign fall_strb   = strb[STRB_FALL_BIT];
  assign glitch_strb = strb[STRB_GLITCH_BIT];

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debounce filter: CH independent debounce_ch instances plus a
// registered any_strb summarising accepted edges across all channels.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int unsigned     CH      = 8,
  parameter int unsigned     DW      = 20,
  parameter logic [DW-1:0]   RISE_TH = DW'(DEBOUNCE_DEFAULT_TH),
  parameter logic [DW-1:0]   FALL_TH = DW'(DEBOUNCE_DEFAULT_TH),
  parameter logic [CH-1:0]   RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [CH-1:0] signal_in,
  output logic [CH-1:0] signal_out,
  output logic [CH-1:0] rise_strb,
  output logic [CH-1:0] fall_strb,
  output logic [CH-1:0] glitch_strb,
  output logic          any_strb
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    debounce_ch #(
      .DW      (DW),
      .RISE_TH (RISE_TH),
      .FALL_TH (FALL_TH),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .signal_in   (signal_in[i]),
      .signal_out  (signal_out[i]),
      .rise_strb   (rise_strb[i]),
      .fall_strb   (fall_strb[i]),
      .glitch_strb (glitch_strb[i])
    );
  end

  // Glitches are deliberately left out: any_strb flags accepted edges only.
  always_ff @(posedge clk) begin
    if (reset) any_strb <= 1'b0;
    else       any_strb <= |{rise_strb, fall_strb};
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: three instances cover asymmetric
// thresholds with RST_VAL=8'hA5, glitch/enable/reset behaviour, and a
// narrow counter at its maximum threshold.
module tb_debounce_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst_a, en_a, any_a;
  logic [7:0] sig_a, out_a, rise_a, fall_a, glitch_a;
  logic       rst_b, en_b, any_b;
  logic [7:0] sig_b, out_b, rise_b, fall_b, glitch_b;
  logic       rst_c, en_c, any_c;
  logic [0:0] sig_c, out_c, rise_c, fall_c, glitch_c;

  debounce_multi #(.CH(8), .DW(20), .RISE_TH(20'd4), .FALL_TH(20'd10), .RST_VAL(8'hA5)) u_a (
    .clk(clk), .reset(rst_a), .enable(en_a), .signal_in(sig_a), .signal_out(out_a),
    .rise_strb(rise_a), .fall_strb(fall_a), .glitch_strb(glitch_a), .any_strb(any_a));

  debounce_multi #(.CH(8), .DW(20), .RISE_TH(20'd8), .FALL_TH(20'd0), .RST_VAL(8'h00)) u_b (
    .clk(clk), .reset(rst_b), .enable(en_b), .signal_in(sig_b), .signal_out(out_b),
    .rise_strb(rise_b), .fall_strb(fall_b), .glitch_strb(glitch_b), .any_strb(any_b));

  debounce_multi #(.CH(1), .DW(4), .RISE_TH(4'd15), .FALL_TH(4'd15), .RST_VAL(1'b0)) u_c (
    .clk(clk), .reset(rst_c), .enable(en_c), .signal_in(sig_c), .signal_out(out_c),
    .rise_strb(rise_c), .fall_strb(fall_c), .glitch_strb(glitch_c), .any_strb(any_c));

  // After tick(n) the bench sits 1ns past the n-th posedge from the call.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int bad;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    sig_a = 8'h00; sig_b = 8'h00; sig_c = 1'b0;
    tick(2);
    checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL reset_out_a: got %h expected %h", out_a, 8'hA5); end
    checks++; if ({rise_a, fall_a, glitch_a, any_a} !== 25'd0) begin errors++; $display("FAIL reset_strb_a: got %h expected 0", {rise_a, fall_a, glitch_a, any_a}); end
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out_b: got %h expected 00", out_b); end
    checks++; if (out_c !== 1'b0) begin errors++; $display("FAIL reset_out_c: got %h expected 0", out_c); end
    sig_a = 8'hA5;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_a !== 8'hA5 || (rise_a | fall_a | glitch_a) !== 8'h00 || any_a !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_hold_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_fall_asym;
    sig_a = 8'hA4;
    tick(11);
    checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL fall_early: got %h expected %h", out_a, 8'hA5); end
    tick(1);
    checks++; if (out_a !== 8'hA4) begin errors++; $display("FAIL fall_out: got %h expected %h", out_a, 8'hA4); end
    checks++; if ({fall_a, rise_a} !== 16'h0100) begin errors++; $display("FAIL fall_strb: got %h expected 0100", {fall_a, rise_a}); end
    tick(1);
    checks++; if ({fall_a, any_a} !== 9'h001) begin errors++; $display("FAIL fall_any: got %h expected 001", {fall_a, any_a}); end
    tick(1);
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL fall_any_end: got %b expected 0", any_a); end
  endtask

  task automatic test_clean_rise;
    sig_a = 8'hA5;
    tick(5);
    checks++; if (out_a !== 8'hA4) begin errors++; $display("FAIL rise_early: got %h expected %h", out_a, 8'hA4); end
    tick(1);
    checks++; if (out_a !== 8'hA5) begin errors++; $display("FAIL rise_out: got %h expected %h", out_a, 8'hA5); end
    checks++; if ({rise_a, fall_a, any_a} !== 17'h00200) begin errors++; $display("FAIL rise_strb: got %h expected 00200", {rise_a, fall_a, any_a}); end
    tick(1);
    checks++; if ({rise_a, any_a} !== 9'h001) begin errors++; $display("FAIL rise_any: got %h expected 001", {rise_a, any_a}); end
    tick(1);
    checks++; if (any_a !== 1'b0) begin errors++; $display("FAIL rise_any_end: got %b expected 0", any_a); end
  endtask

  task automatic test_multi;
    sig_b = 8'hFF;
    tick(9);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL multi_early: got %h expected 00", out_b); end
    tick(1);
    checks++; if ({out_b, rise_b} !== 16'hFFFF) begin errors++; $display("FAIL multi_rise: got %h expected FFFF", {out_b, rise_b}); end
    checks++; if (any_b !== 1'b0) begin errors++; $display("FAIL multi_any_lag: got %b expected 0", any_b); end
    tick(1);
    checks++; if ({rise_b, any_b} !== 9'h001) begin errors++; $display("FAIL multi_any: got %h expected 001", {rise_b, any_b}); end
    tick(1);
    checks++; if (any_b !== 1'b0) begin errors++; $display("FAIL multi_any_single: got %b expected 0", any_b); end
  endtask

  task automatic test_th_zero;
    sig_b = 8'h00;
    tick(2);
    checks++; if (out_b !== 8'hFF) begin errors++; $display("FAIL th0_early: got %h expected FF", out_b); end
    tick(1);
    checks++; if ({out_b, fall_b} !== 16'h00FF) begin errors++; $display("FAIL th0_fall: got %h expected 00FF", {out_b, fall_b}); end
    tick(1);
    checks++; if ({fall_b, any_b} !== 9'h001) begin errors++; $display("FAIL th0_any: got %h expected 001", {fall_b, any_b}); end
    tick(3);
  endtask

  task automatic test_glitch;
    sig_b = 8'h08;
    tick(5);
    sig_b = 8'h00;
    tick(1);
    checks++; if (glitch_b !== 8'h00) begin errors++; $display("FAIL glitch_early: got %h expected 00", glitch_b); end
    tick(1);
    checks++; if ({glitch_b, rise_b, out_b} !== 24'h080000) begin errors++; $display("FAIL glitch_pulse: got %h expected 080000", {glitch_b, rise_b, out_b}); end
    tick(1);
    checks++; if ({glitch_b, any_b} !== 9'h000) begin errors++; $display("FAIL glitch_end: got %h expected 000", {glitch_b, any_b}); end
    tick(10);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL glitch_hold: got %h expected 00", out_b); end
  endtask

  task automatic test_enable;
    int bad;
    sig_b = 8'h08;
    tick(5);
    en_b = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (out_b !== 8'h00 || (rise_b | glitch_b) !== 8'h00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL enable_off: got %0d bad cycles expected 0", bad); end
    en_b = 1'b1;
    tick(7);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reenable_early: got %h expected 00", out_b); end
    tick(1);
    checks++; if ({out_b, rise_b} !== 16'h0808) begin errors++; $display("FAIL reenable_rise: got %h expected 0808", {out_b, rise_b}); end
    tick(2);
  endtask

  task automatic test_reset_mid;
    sig_b = 8'hF8;
    tick(4);
    rst_b = 1'b1;
    tick(1);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL midrst_out: got %h expected 00", out_b); end
    checks++; if ({rise_b, fall_b, glitch_b, any_b} !== 25'd0) begin errors++; $display("FAIL midrst_strb: got %h expected 0", {rise_b, fall_b, glitch_b, any_b}); end
    rst_b = 1'b0;
    tick(9);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL midrst_requal_early: got %h expected 00", out_b); end
    tick(1);
    checks++; if ({out_b, rise_b} !== 16'hF8F8) begin errors++; $display("FAIL midrst_requal: got %h expected F8F8", {out_b, rise_b}); end
  endtask

  task automatic test_boundary;
    int bad;
    sig_c = 1'b1;
    tick(16);
    checks++; if (out_c !== 1'b0) begin errors++; $display("FAIL max_th_early: got %b expected 0", out_c); end
    tick(1);
    checks++; if ({out_c, rise_c} !== 2'b11) begin errors++; $display("FAIL max_th_rise: got %b expected 11", {out_c, rise_c}); end
    tick(1);
    checks++; if ({rise_c, any_c} !== 2'b01) begin errors++; $display("FAIL max_th_any: got %b expected 01", {rise_c, any_c}); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_c !== 1'b1 || {rise_c, fall_c, glitch_c, any_c} !== 4'b0000) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL max_th_no_wrap: got %0d bad cycles expected 0", bad); end
    sig_c = 1'b0;
    tick(16);
    checks++; if (out_c !== 1'b1) begin errors++; $display("FAIL max_th_fall_early: got %b expected 1", out_c); end
    tick(1);
    checks++; if ({out_c, fall_c} !== 2'b01) begin errors++; $display("FAIL max_th_fall: got %b expected 01", {out_c, fall_c}); end
  endtask

  initial begin
    test_reset;
    test_fall_asym;
    test_clean_rise;
    test_multi;
    test_th_zero;
    test_glitch;
    test_enable;
    test_reset_mid;
    test_boundary;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel debounce filter for mechanical inputs such as card-detect, write-protect and push-buttons, with separate rise and fall qualification times. Each channel synchronises its raw input, qualifies a level change only after it has been stable for the programmed number of cycles, and reports a one-cycle edge strobe on each accepted transition. It also reports a glitch strobe when a pending change is abandoned. The block sits between the board pins and the control FSMs, and replaces per-signal single-bit debouncers.

## Interface
- CH, 8: number of independent channels (1..32).
- DW, 20: counter width in bits.
- RISE_TH, 20'h30D3F: stable cycles required to accept a 0→1 change. A value of 0 is treated as 1.
- FALL_TH, 20'h30D3F: stable cycles required to accept a 1→0 change. A value of 0 is treated as 1.
- RST_VAL, {CH{1'b0}}: reset value of the synchronisers and of signal_out, per channel.

Ports:
- clk  in  1  system clock; everything is in this single domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global filter enable. When low, outputs hold and counters clear.
- signal_in  in  CH  raw asynchronous inputs.
- signal_out  out  CH  debounced levels.
- rise_strb  out  CH  one-cycle pulse when signal_out goes 0→1.
- fall_strb  out  CH  one-cycle pulse when signal_out goes 1→0.
- glitch_strb  out  CH  one-cycle pulse when a pending change is abandoned.
- any_strb  out  1  registered OR of all rise_strb and fall_strb bits from the same edge.

## Operation
Each channel is fully independent. No state is shared between channels.

- **Synchroniser.** On each edge, z1 <= signal_in[i] and z2 <= z1.
- **Pending condition.** pend = (z2 != signal_out[i]) && (z1 == z2).
- **Threshold.** th = signal_out[i] ? FALL_TH : RISE_TH.
- **Counter.** cnt is DW bits.
  - If enable && pend && cnt < th-1: cnt <= cnt+1.
  - If enable && pend && cnt == th-1: signal_out[i] <= z2, cnt <= 0, and the matching rise_strb or fall_strb is set for one cycle.
  - If enable && !pend && cnt != 0: cnt <= 0 and glitch_strb[i] is set for one cycle.
  - If !enable: cnt <= 0. signal_out holds, no strobes are generated, and the synchronisers keep running.
- **Saturation.** cnt never exceeds th-1, so there is no wrap-around.
- **Reset.** On reset: z1, z2 and signal_out <= RST_VAL; cnt <= 0; all strobes <= 0. Reset overrides enable and any pending qualification. After reset, a channel whose input differs from RST_VAL re-qualifies from zero.
- **Simultaneous events.** Each channel produces at most one strobe per cycle. A glitch is impossible on the same edge as an acceptance. any_strb can reflect multiple channels at once.

## Timing
- A clean step on signal_in sampled at edge 0 reaches z2 at edge 1. signal_out changes at edge th+1. The strobe is high during the cycle after edge th+1. Total latency is th+1 clocks from the first sampling edge.
- The strobes are registered and last exactly one cycle. any_strb lags the per-channel strobes by one cycle.
- Any input reversal seen at z1 before acceptance aborts the pending change:
  - cnt clears on the next edge;
  - glitch_strb pulses if cnt was nonzero;
  - the acceptance timer restarts from 0 when the input settles again.
- Deasserting enable mid-count clears cnt and produces no glitch_strb. Re-enabling restarts qualification.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Sub-module debounce_ch holds one channel: synchroniser, counter, threshold mux and strobe flops. The top level instantiates it CH times in a generate loop and adds the any_strb flop.
- The shared constants package/include holds:
  - the default threshold value;
  - the threshold clamp rule (0→1);
  - the strobe encoding.
- These constants are shared with the existing single-bit debounce users.

## Test plan
- **Reset values.** Reset with RST_VAL=8'hA5 → signal_out=8'hA5, all strobes 0. Held input 8'hA5 afterwards → no strobes.
- **Clean rise.** RISE_TH=4, ch0 steps 0→1 at edge 0 → signal_out[0]=1 at edge 5, rise_strb[0] high one cycle, any_strb one cycle later. Other channels unchanged.
- **Asymmetric fall.** FALL_TH=10 → fall accepted at edge 11. Repeat with th=0 → accepted at edge 2, same as th=1.
- **Glitch.** RISE_TH=8, ch3 high for 5 cycles then low → glitch_strb[3] pulses once, signal_out[3] stays 0, no rise_strb.
- **Enable and reset mid-count.** Enable dropped at cnt=3 → no change, no glitch. Re-enable → full 8-cycle requalification. Reset asserted mid-count → all outputs return to RST_VAL on the next edge.
- **Multi-channel and boundary.** All 8 channels toggled on the same edge → all strobes in the same cycle, single any_strb pulse. th = 2^DW-1 → acceptance with no counter wrap.
